// File: rtl/sine_arbiter.sv
// Round-robin front end sharing one sine engine between NREQ requesters.
// Holds engStart through the engine handshake and aborts via watchdog if done never comes.
module sine_arbiter #(
  parameter int NREQ    = 4,
  parameter int XW      = 16,
  parameter int RW      = 18,
  parameter int TIMEOUT = 63
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic [NREQ-1:0]           reqValid,
  input  logic [NREQ*XW-1:0]        reqX,
  output logic [NREQ-1:0]           reqReady,
  output logic [NREQ-1:0]           rspValid,
  output logic [RW-1:0]             rspData,
  output logic                      rspErr,
  output logic                      engStart,
  output logic [XW-1:0]             engX,
  input  logic                      engDone,
  input  logic [RW-1:0]             engR,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grantId
);

  localparam int          GW  = $clog2(NREQ);
  localparam int          WDW = $clog2(TIMEOUT + 1);
  localparam int unsigned N   = NREQ;
  localparam logic [WDW-1:0]  WD_MAX  = WDW'(TIMEOUT);
  localparam logic [NREQ-1:0] ONE_HOT = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t         state;
  // Holds the search start (last grant + 1) rather than the last grant itself,
  // so a zero reset value makes the first search begin at requester 0.
  logic [GW-1:0]  start_ptr;
  logic [WDW-1:0] wd;

  logic [XW-1:0]  req_x_arr [NREQ];
  logic           any_req;
  logic [GW-1:0]  win;
  logic [GW-1:0]  win_next;
  logic [XW-1:0]  win_x;

  for (genvar i = 0; i < NREQ; i++) begin : g_x
    assign req_x_arr[i] = reqX[i*XW +: XW];
  end

  always_comb begin
    int unsigned sum;
    logic [GW-1:0] idx;
    any_req = 1'b0;
    win     = '0;
    sum     = 0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = 32'(start_ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = sum[GW-1:0];
      if (!any_req && reqValid[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
    win_x    = req_x_arr[win];
    win_next = (32'(win) == N - 1) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      start_ptr <= '0;
      wd        <= '0;
      reqReady  <= '0;
      rspValid  <= '0;
      rspData   <= '0;
      rspErr    <= 1'b0;
      engStart  <= 1'b0;
      engX      <= '0;
      grantId   <= '0;
    end else begin
      reqReady <= '0;
      rspValid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            engX      <= win_x;
            grantId   <= win;
            start_ptr <= win_next;
            reqReady  <= ONE_HOT << win;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          engStart <= 1'b1;
          wd       <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (engDone) begin
            rspData  <= engR;
            rspErr   <= 1'b0;
            rspValid <= ONE_HOT << grantId;
            engStart <= 1'b0;
            state    <= RESP;
          end else if (wd == WD_MAX) begin
            rspData  <= '0;
            rspErr   <= 1'b1;
            rspValid <= ONE_HOT << grantId;
            engStart <= 1'b0;
            state    <= RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESP: begin
          rspErr <= 1'b0;
          state  <= DRAIN;
        end
        DRAIN: begin
          if (!engDone) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sine_arbiter.sv
// Scenario bench for sine_arbiter with a behavioural engine stub (done after 26 cycles, R = x+1).
module tb_sine_arbiter;

  localparam int NREQ = 4;
  localparam int XW   = 16;
  localparam int RW   = 18;
  localparam int TO   = 63;
  localparam int LAT  = 26;

  logic              clk;
  logic              rstN;
  logic [NREQ-1:0]   reqValid;
  logic [NREQ*XW-1:0] reqX;
  logic [NREQ-1:0]   reqReady;
  logic [NREQ-1:0]   rspValid;
  logic [RW-1:0]     rspData;
  logic              rspErr;
  logic              engStart;
  logic [XW-1:0]     engX;
  logic              engDone;
  logic [RW-1:0]     engR;
  logic              busy;
  logic [1:0]        grantId;

  typedef struct packed {
    logic [1:0]    id;
    logic [RW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  int hang       = 0;
  int hold_extra = 0;
  int cnt;
  int hold_cnt;

  bit              auto_drop = 1'b1;
  bit              overlap   = 1'b0;
  logic [NREQ-1:0] seen_ready;
  logic [NREQ-1:0] seen_rsp;
  int              rdy_cnt;
  int              start_cnt;

  sine_arbiter #(
    .NREQ    (NREQ),
    .XW      (XW),
    .RW      (RW),
    .TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .reqValid (reqValid),
    .reqX     (reqX),
    .reqReady (reqReady),
    .rspValid (rspValid),
    .rspData  (rspData),
    .rspErr   (rspErr),
    .engStart (engStart),
    .engX     (engX),
    .engDone  (engDone),
    .engR     (engR),
    .busy     (busy),
    .grantId  (grantId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine stub: counts start-high cycles, raises done, holds it until start
  // has been seen low for hold_extra further cycles.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt      <= 0;
      hold_cnt <= 0;
      engDone  <= 1'b0;
      engR     <= '0;
    end else if (engStart && !engDone) begin
      cnt <= cnt + 1;
      if (cnt == LAT - 1 && hang == 0) begin
        engDone <= 1'b1;
        engR    <= {2'b00, engX} + 18'd1;
      end
    end else if (!engStart) begin
      cnt <= 0;
      if (engDone) begin
        if (hold_cnt == hold_extra) begin
          engDone  <= 1'b0;
          hold_cnt <= 0;
        end else begin
          hold_cnt <= hold_cnt + 1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1);
  end

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      seen_ready |= reqReady;
      seen_rsp   |= rspValid;
      if (reqReady != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok        = 1'b0;
    rdy_cnt   = 0;
    start_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      seen_ready |= reqReady;
      seen_rsp   |= rspValid;
      if (reqReady != '0) rdy_cnt++;
      if (engStart) start_cnt++;
      if (reqReady != '0 && rspValid != '0) overlap = 1'b1;
      if (auto_drop) reqValid &= ~reqReady;
      if (rspValid != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset;
    reqValid = '0;
    rstN     = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reqValid = '0;
    reqX     = '0;
    rstN     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (engStart !== 1'b0) begin failures++; $display("FAIL reset_engStart: got %b want 0", engStart); end
    checks++; if (reqReady !== 4'b0) begin failures++; $display("FAIL reset_reqReady: got %b want 0000", reqReady); end
    checks++; if (rspValid !== 4'b0) begin failures++; $display("FAIL reset_rspValid: got %b want 0000", rspValid); end
    checks++; if (rspData !== 18'h0 || rspErr !== 1'b0) begin failures++; $display("FAIL reset_rsp: got %h/%b want 0/0", rspData, rspErr); end
    checks++; if (grantId !== 2'd0 || engX !== 16'h0) begin failures++; $display("FAIL reset_grant: got %0d/%h want 0/0", grantId, engX); end
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    exp_t e;
    bit   ok;
    int   lat;
    sb.push_back('{id: 2'd2, data: 18'h01235, err: 1'b0});
    reqX[2*XW +: XW] = 16'h1234;
    reqValid = 4'b0100;
    wait_ready(10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_ready_timeout: got none want reqReady"); end
    checks++; if (reqReady !== 4'b0100) begin failures++; $display("FAIL single_reqReady: got %b want 0100", reqReady); end
    checks++; if (engStart !== 1'b0) begin failures++; $display("FAIL single_start_early: got %b want 0", engStart); end
    checks++; if (grantId !== 2'd2 || engX !== 16'h1234) begin failures++; $display("FAIL single_grant: got %0d/%h want 2/1234", grantId, engX); end
    reqValid = '0;
    @(negedge clk);
    checks++; if (engStart !== 1'b1 || reqReady !== 4'b0) begin failures++; $display("FAIL single_start: got %b/%b want 1/0000", engStart, reqReady); end
    lat = 0;
    while (!engDone && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (engDone !== 1'b1) begin failures++; $display("FAIL single_done_timeout: got %b want 1", engDone); end
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (rspValid !== (4'b1 << e.id)) begin failures++; $display("FAIL single_rspValid: got %b want %b", rspValid, 4'b1 << e.id); end
    checks++; if (rspData !== e.data || rspErr !== e.err) begin failures++; $display("FAIL single_rspData: got %h/%b want %h/%b", rspData, rspErr, e.data, e.err); end
    checks++; if (engStart !== 1'b0) begin failures++; $display("FAIL single_start_drop: got %b want 0", engStart); end
    @(negedge clk);
    checks++; if (rspValid !== 4'b0) begin failures++; $display("FAIL single_pulse: got %b want 0000", rspValid); end
    wait_idle(10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_idle_timeout: got busy want idle"); end
  endtask

  task automatic test_round_robin;
    logic [XW-1:0] xs [NREQ];
    logic [1:0]    order [5];
    exp_t e;
    bit   ok;
    xs[0] = 16'h1000; xs[1] = 16'h2000; xs[2] = 16'hFFFF; xs[3] = 16'h0000;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    apply_reset();
    for (int i = 0; i < NREQ; i++) reqX[i*XW +: XW] = xs[i];
    for (int i = 0; i < 5; i++) sb.push_back('{id: order[i], data: {2'b00, xs[order[i]]} + 18'd1, err: 1'b0});
    auto_drop = 1'b0;
    overlap   = 1'b0;
    reqValid  = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_rsp(100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rr_timeout_%0d: got no rsp want rsp", n); end
      checks++; if (rdy_cnt != 1) begin failures++; $display("FAIL rr_ready_count_%0d: got %0d want 1", n, rdy_cnt); end
      e = sb.pop_front();
      checks++; if (rspValid !== (4'b1 << e.id)) begin failures++; $display("FAIL rr_order_%0d: got %b want %b", n, rspValid, 4'b1 << e.id); end
      checks++; if (rspData !== e.data || rspErr !== e.err) begin failures++; $display("FAIL rr_data_%0d: got %h/%b want %h/%b", n, rspData, rspErr, e.data, e.err); end
    end
    reqValid  = '0;
    auto_drop = 1'b1;
    wait_idle(20, ok);
    checks++; if (!ok || overlap) begin failures++; $display("FAIL rr_idle_overlap: got idle=%b overlap=%b want 1/0", ok, overlap); end
  endtask

  task automatic test_timeout;
    exp_t e;
    bit   ok;
    hang = 1;
    sb.push_back('{id: 2'd1, data: 18'h0, err: 1'b1});
    reqX[1*XW +: XW] = 16'h5555;
    reqValid = 4'b0010;
    wait_rsp(TO + 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL to_timeout: got no rsp want rsp"); end
    checks++; if (start_cnt != TO + 1) begin failures++; $display("FAIL to_wait_cycles: got %0d want %0d", start_cnt, TO + 1); end
    e = sb.pop_front();
    checks++; if (rspValid !== (4'b1 << e.id)) begin failures++; $display("FAIL to_rspValid: got %b want %b", rspValid, 4'b1 << e.id); end
    checks++; if (rspData !== e.data || rspErr !== e.err) begin failures++; $display("FAIL to_rsp: got %h/%b want %h/%b", rspData, rspErr, e.data, e.err); end
    hang = 0;
    wait_idle(20, ok);
    sb.push_back('{id: 2'd2, data: 18'h0ABCE, err: 1'b0});
    reqX[2*XW +: XW] = 16'hABCD;
    reqValid = 4'b0100;
    wait_rsp(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL to_next_timeout: got no rsp want rsp"); end
    e = sb.pop_front();
    checks++; if (rspValid !== (4'b1 << e.id) || rspData !== e.data || rspErr !== e.err) begin
      failures++; $display("FAIL to_next_rsp: got %b/%h/%b want %b/%h/%b", rspValid, rspData, rspErr, 4'b1 << e.id, e.data, e.err);
    end
    wait_idle(20, ok);
  endtask

  task automatic test_drain_hold;
    exp_t e;
    bit   ok;
    bit   viol;
    int   dc;
    hold_extra = 3;
    sb.push_back('{id: 2'd3, data: 18'h00034, err: 1'b0});
    sb.push_back('{id: 2'd0, data: 18'h00101, err: 1'b0});
    reqX[3*XW +: XW] = 16'h0033;
    reqX[0*XW +: XW] = 16'h0100;
    reqValid = 4'b1001;
    wait_rsp(100, ok);
    e = sb.pop_front();
    checks++; if (!ok || rspValid !== (4'b1 << e.id) || rspData !== e.data) begin
      failures++; $display("FAIL drain_first_rsp: got %b/%h want %b/%h", rspValid, rspData, 4'b1 << e.id, e.data);
    end
    dc   = 0;
    viol = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (engDone && (engStart || reqReady != '0)) viol = 1'b1;
      if (!busy) break;
      dc++;
    end
    checks++; if (dc != 4) begin failures++; $display("FAIL drain_cycles: got %0d want 4", dc); end
    checks++; if (busy !== 1'b0 || engDone !== 1'b0) begin failures++; $display("FAIL drain_exit: got busy=%b done=%b want 0/0", busy, engDone); end
    checks++; if (viol) begin failures++; $display("FAIL drain_start_during_done: got 1 want 0"); end
    wait_rsp(100, ok);
    e = sb.pop_front();
    checks++; if (!ok || rspValid !== (4'b1 << e.id) || rspData !== e.data) begin
      failures++; $display("FAIL drain_second_rsp: got %b/%h want %b/%h", rspValid, rspData, 4'b1 << e.id, e.data);
    end
    hold_extra = 0;
    wait_idle(20, ok);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit   ok;
    reqX[1*XW +: XW] = 16'h7777;
    reqValid = 4'b0010;
    wait_ready(10, ok);
    reqValid = '0;
    repeat (5) @(negedge clk);
    checks++; if (engStart !== 1'b1) begin failures++; $display("FAIL mid_in_wait: got %b want 1", engStart); end
    #2 rstN = 1'b0;
    #1;
    checks++; if (engStart !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_async: got start=%b busy=%b want 0/0", engStart, busy); end
    checks++; if (reqReady !== 4'b0 || rspValid !== 4'b0) begin failures++; $display("FAIL mid_async_pulses: got %b/%b want 0000/0000", reqReady, rspValid); end
    @(negedge clk);
    seen_ready = '0;
    seen_rsp   = '0;
    reqX[0*XW +: XW] = 16'h0042;
    reqValid = 4'b0011;
    rstN     = 1'b1;
    wait_ready(10, ok);
    checks++; if (!ok || reqReady !== 4'b0001 || grantId !== 2'd0) begin
      failures++; $display("FAIL mid_first_grant: got %b/%0d want 0001/0", reqReady, grantId);
    end
    reqValid = '0;
    sb.push_back('{id: 2'd0, data: 18'h00043, err: 1'b0});
    wait_rsp(100, ok);
    e = sb.pop_front();
    checks++; if (!ok || rspValid !== (4'b1 << e.id) || rspData !== e.data) begin
      failures++; $display("FAIL mid_rsp: got %b/%h want %b/%h", rspValid, rspData, 4'b1 << e.id, e.data);
    end
    checks++; if (seen_rsp[1] !== 1'b0 || seen_ready[1] !== 1'b0) begin failures++; $display("FAIL mid_no_stale: got rsp=%b rdy=%b want 0/0", seen_rsp[1], seen_ready[1]); end
    wait_idle(20, ok);
  endtask

  task automatic test_withdraw;
    exp_t e;
    bit   ok;
    seen_ready = '0;
    seen_rsp   = '0;
    reqX[0*XW +: XW] = 16'h0010;
    reqX[1*XW +: XW] = 16'h0011;
    reqX[3*XW +: XW] = 16'h0013;
    sb.push_back('{id: 2'd0, data: 18'h00011, err: 1'b0});
    sb.push_back('{id: 2'd3, data: 18'h00014, err: 1'b0});
    reqValid = 4'b0001;
    wait_ready(10, ok);
    reqValid = 4'b1010;
    wait_rsp(100, ok);
    e = sb.pop_front();
    checks++; if (!ok || rspValid !== (4'b1 << e.id) || rspData !== e.data) begin
      failures++; $display("FAIL wd_first_rsp: got %b/%h want %b/%h", rspValid, rspData, 4'b1 << e.id, e.data);
    end
    @(negedge clk);
    reqValid[1] = 1'b0;
    wait_rsp(100, ok);
    e = sb.pop_front();
    checks++; if (!ok || rspValid !== (4'b1 << e.id) || rspData !== e.data) begin
      failures++; $display("FAIL wd_grant3: got %b/%h want %b/%h", rspValid, rspData, 4'b1 << e.id, e.data);
    end
    checks++; if (seen_ready[1] !== 1'b0 || seen_rsp[1] !== 1'b0) begin failures++; $display("FAIL wd_req1_untouched: got rdy=%b rsp=%b want 0/0", seen_ready[1], seen_rsp[1]); end
    reqValid = '0;
    wait_idle(20, ok);
    checks++; if (!ok || sb.size() != 0) begin failures++; $display("FAIL wd_end: got idle=%b left=%0d want 1/0", ok, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_drain_hold();
    test_reset_mid();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
